// File: rtl/diff_tx.sv
// Pulse-width coded serial transmitter: sync low/high pair, 26 MSB-first data bits
// (short or long low phase per bit), then a low trailer before returning to idle-high.
module diff_tx #(
  parameter int DATA_PERIOD               = 20,
  parameter int HALF_DATA_PERIOD          = 10,
  parameter int QUARTER_DATA_PERIOD       = 5,
  parameter int THREE_QUARTER_DATA_PERIOD = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [25:0] code_in,
  input  logic        trigger_in,
  output logic        data_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [2:0]  state_out
);

  localparam int CW = $clog2(DATA_PERIOD) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SL    = 3'd1;
  localparam logic [2:0] S_SH    = 3'd2;
  localparam logic [2:0] S_DL    = 3'd3;
  localparam logic [2:0] S_DH    = 3'd4;
  localparam logic [2:0] S_TRAIL = 3'd5;

  localparam logic [CW-1:0] L_ONE   = CW'(1);
  localparam logic [CW-1:0] L_HALF  = CW'(HALF_DATA_PERIOD);
  localparam logic [CW-1:0] L_SHORT = CW'(QUARTER_DATA_PERIOD);
  localparam logic [CW-1:0] L_LONG  = CW'(THREE_QUARTER_DATA_PERIOD);

  logic [2:0]    r_state;
  logic          r_data;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_idx;
  logic [25:0]   r_buf;

  logic [CW-1:0] w_lowLen;
  logic [CW-1:0] w_highLen;

  // The bit being sent always sits in the buffer MSB; a one stretches the low phase.
  always_comb begin
    w_lowLen  = r_buf[25] ? L_LONG  : L_SHORT;
    w_highLen = r_buf[25] ? L_SHORT : L_LONG;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= 5'd25;
      r_buf   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_data <= 1'b1;
          if (trigger_in) begin
            r_state <= S_SL;
            r_data  <= 1'b0;
            r_cnt   <= L_ONE;
            r_idx   <= 5'd25;
            r_buf   <= code_in;
          end
        end
        S_SL: begin
          if (r_cnt == L_HALF) begin
            r_state <= S_SH;
            r_data  <= 1'b1;
            r_cnt   <= L_ONE;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        S_SH: begin
          if (r_cnt == L_HALF) begin
            r_state <= S_DL;
            r_data  <= 1'b0;
            r_cnt   <= L_ONE;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        S_DL: begin
          if (r_cnt == w_lowLen) begin
            r_state <= S_DH;
            r_data  <= 1'b1;
            r_cnt   <= L_ONE;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        S_DH: begin
          if (r_cnt == w_highLen) begin
            r_data <= 1'b0;
            r_cnt  <= L_ONE;
            if (r_idx != 5'd0) begin
              r_state <= S_DL;
              r_idx   <= r_idx - 5'd1;
              r_buf   <= {r_buf[24:0], 1'b0};
            end else begin
              r_state <= S_TRAIL;
            end
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        S_TRAIL: begin
          if (r_cnt == L_HALF) begin
            r_state <= S_IDLE;
            r_data  <= 1'b1;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_data  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign busy_out  = (r_state != S_IDLE);
  assign done_out  = r_done;
  assign state_out = r_state;

endmodule

// File: tb/tb_diff_tx.sv
// Directed bench for diff_tx: captures the line per cycle, compares it with an
// expected waveform and decodes it back to a code word like a receiver would.
module tb_diff_tx;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [25:0] code_in;
  logic        trigger_in;
  logic        data_out;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  state_out;

  int checkCount = 0;
  int errorCount = 0;

  logic       capData  [0:1199];
  logic       capBusy  [0:1199];
  logic       capDone  [0:1199];
  logic [2:0] capState [0:1199];

  diff_tx dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .code_in    (code_in),
    .trigger_in (trigger_in),
    .data_out   (data_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .state_out  (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected line level in cycle i after the accepting edge, default timing.
  function automatic logic expLevel(input logic [25:0] code, input int i);
    int   j;
    logic b;
    if (i < 10) return 1'b0;
    if (i < 20) return 1'b1;
    if (i < 540) begin
      j = i - 20;
      b = code[25 - j / 20];
      return ((j % 20) < (b ? 15 : 5)) ? 1'b0 : 1'b1;
    end
    if (i < 550) return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic [25:0] code);
    @(negedge clk_in);
    code_in    = code;
    trigger_in = 1'b1;
    @(posedge clk_in);
  endtask

  task automatic captureCycles(input int n, input bit holdTrig, input int injectAt, input logic [25:0] injectCode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      capData[i]  = data_out;
      capBusy[i]  = busy_out;
      capDone[i]  = done_out;
      capState[i] = state_out;
      if (i == injectAt) begin
        trigger_in = 1'b1;
        code_in    = injectCode;
      end else if (!holdTrig) begin
        trigger_in = 1'b0;
      end
    end
  endtask

  task automatic checkFrame(input string tag, input int base, input logic [25:0] code);
    int          waveErr;
    int          busyErr;
    int          doneCount;
    int          doneIdx;
    int          pos;
    int          lowRun;
    logic [25:0] decoded;
    waveErr   = 0;
    busyErr   = 0;
    doneCount = 0;
    doneIdx   = -1;
    for (int i = 0; i <= 550; i++) begin
      if (capData[base+i] !== expLevel(code, i)) waveErr++;
      if (capBusy[base+i] !== (i < 550)) busyErr++;
      if (capDone[base+i] === 1'b1) begin
        doneCount++;
        doneIdx = i;
      end
    end
    checkOutput({tag, " wave"}, waveErr, 0);
    checkOutput({tag, " busy"}, busyErr, 0);
    checkOutput({tag, " done count"}, doneCount, 1);
    checkOutput({tag, " done cycle"}, doneIdx, 550);
    checkOutput({tag, " state SL"}, capState[base], 3'd1);
    checkOutput({tag, " state SH"}, capState[base+10], 3'd2);
    checkOutput({tag, " state DL"}, capState[base+20], 3'd3);
    checkOutput({tag, " state TRAIL"}, capState[base+545], 3'd5);
    checkOutput({tag, " state IDLE"}, capState[base+550], 3'd0);
    pos     = 20;
    decoded = '0;
    for (int b = 0; b < 26; b++) begin
      lowRun = 0;
      while (pos < 550 && capData[base+pos] === 1'b0) begin
        lowRun++;
        pos++;
      end
      while (pos < 551 && capData[base+pos] === 1'b1) pos++;
      decoded = {decoded[24:0], (lowRun > 10)};
    end
    checkOutput({tag, " decoded"}, decoded, code);
  endtask

  initial begin
    int doneSeen;
    int waited;
    rst_in     = 1'b0;
    trigger_in = 1'b0;
    code_in    = '0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset data", data_out, 1);
    checkOutput("reset busy", busy_out, 0);
    checkOutput("reset done", done_out, 0);
    checkOutput("reset state", state_out, 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("idle state", state_out, 0);
    checkOutput("idle data", data_out, 1);

    applyStimulus(26'h0000000);
    captureCycles(560, 1'b0, -1, '0);
    checkFrame("zeros", 0, 26'h0000000);

    applyStimulus(26'h3FFFFFF);
    captureCycles(560, 1'b0, -1, '0);
    checkFrame("ones", 0, 26'h3FFFFFF);

    applyStimulus(26'h2AAAAAA);
    captureCycles(560, 1'b0, -1, '0);
    checkFrame("alt", 0, 26'h2AAAAAA);

    // A trigger with a new code mid-frame must neither alter nor queue a frame.
    applyStimulus(26'h0F0F0F0);
    captureCycles(560, 1'b0, 200, 26'h3FFFFFF);
    checkFrame("ignored trig", 0, 26'h0F0F0F0);
    checkOutput("ignored trig not queued", capState[555], 3'd0);

    applyStimulus(26'h0000000);
    captureCycles(301, 1'b0, -1, '0);
    rst_in = 1'b0;
    #1;
    checkOutput("midrst data", data_out, 1);
    checkOutput("midrst busy", busy_out, 0);
    checkOutput("midrst state", state_out, 0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out === 1'b1) doneSeen++;
    end
    rst_in = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      if (done_out === 1'b1) doneSeen++;
    end
    checkOutput("midrst no done", doneSeen, 0);
    applyStimulus(26'h155AA33);
    captureCycles(560, 1'b0, -1, '0);
    checkFrame("after rst", 0, 26'h155AA33);

    // Trigger held across reset release, then held for back-to-back frames.
    @(negedge clk_in);
    rst_in     = 1'b0;
    code_in    = 26'h1234567;
    trigger_in = 1'b1;
    @(negedge clk_in);
    checkOutput("held trig in reset", state_out, 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    captureCycles(1102, 1'b1, -1, '0);
    checkFrame("b2b first", 0, 26'h1234567);
    checkFrame("b2b second", 551, 26'h1234567);
    checkOutput("b2b gap high", capData[550], 1);
    checkOutput("b2b gap end", capData[551], 0);
    trigger_in = 1'b0;
    waited = 0;
    while (busy_out === 1'b1 && waited < 700) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("b2b drain", busy_out, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
